// File: rtl/feistel_iter_core.sv
// Iterative Feistel engine: one DES-style round per clock over a 64-bit block.
// Round keys are fetched each RUN cycle through key_idx/round_key; all outputs are registered.
module feistel_iter_core #(
    parameter int unsigned ROUNDS     = 16,
    parameter int unsigned CNT_W      = 5,
    parameter bit          FINAL_SWAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      block_in,
    input  logic             decrypt,
    output logic [CNT_W-1:0] key_idx,
    input  logic [47:0]      round_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      block_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    // Eight DES S-boxes, each 4 rows x 16 columns of nibbles, entry 0 at the MSB end.
    localparam logic [2047:0] SBOX_ALL = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // E expansion is a sliding 6-bit window, stride 4, over R with wrap-around.
    function automatic logic [47:0] expand_e(input logic [31:0] r);
        logic [33:0] ring;
        logic [47:0] e;
        ring = {r[0], r, r[31]};
        e    = 48'd0;
        for (int k = 0; k < 8; k++) begin
            e[47-6*k -: 6] = ring[33-4*k -: 6];
        end
        return e;
    endfunction

    function automatic logic [31:0] sbox_layer(input logic [47:0] x);
        logic [5:0]  six;
        logic [5:0]  idx;
        logic [31:0] y;
        y = 32'd0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            idx = {six[5], six[0], six[4:1]};
            y[31-4*b -: 4] = SBOX_ALL[2047 - 256*b - 4*int'(idx) -: 4];
        end
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] s);
        return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
                s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
                s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
                s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
    endfunction

    function automatic logic [31:0] fblock(input logic [31:0] r_in, input logic [47:0] r_key);
        return perm_p(sbox_layer(expand_e(r_in) ^ r_key));
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       l_q, l_d, r_q, r_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  key_idx_q, key_idx_d;
    logic [63:0]       block_out_q, block_out_d;
    logic [31:0]       f_out_s;

    assign f_out_s = fblock(r_q, round_key);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d     = block_in[63:32];
                    r_d     = block_in[31:0];
                    mode_d  = decrypt;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                l_d = r_q;
                r_d = l_q ^ f_out_s;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, so every port is driven straight from a flop.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        if ((state_d == ST_RUN) && mode_d) begin
            key_idx_d = LAST_CNT - cnt_d;
        end else begin
            key_idx_d = cnt_d;
        end
        if (state_d == ST_DONE) begin
            block_out_d = FINAL_SWAP ? {l_d, r_d} : {r_d, l_d};
        end else begin
            block_out_d = 64'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            l_q         <= 32'd0;
            r_q         <= 32'd0;
            cnt_q       <= {CNT_W{1'b0}};
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            key_idx_q   <= {CNT_W{1'b0}};
            block_out_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            key_idx_q   <= key_idx_d;
            block_out_q <= block_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign key_idx   = key_idx_q;
    assign block_out = block_out_q;

endmodule

// File: doc/feistel_iter_core.md
Name: feistel_iter_core

Overview:
- Iterative, parametrised Feistel engine. Reuses the existing fblock F-function and runs ROUNDS rounds on one 64-bit block, one round per clock.
- Supports encrypt and decrypt by reversing the round-key order.
- Round keys come from an external key-schedule store through a key_idx/round_key lookup.
- Sits between the IP stage and the FP stage of the DES datapath, replacing the unrolled chain of single-round instances. IP and FP are not part of this block.

Parameters:
- ROUNDS, 16, number of Feistel rounds per block; legal range 1..31.
- CNT_W, 5, width of the round counter and key_idx; must satisfy 2^CNT_W > ROUNDS.
- FINAL_SWAP, 0, 0 gives output {R_n, L_n} (DES pre-output convention, no swap after the last round); 1 gives output {L_n, R_n}.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  block_in/decrypt are valid.
- in_ready  out  1  core can accept a block.
- block_in  in  64  input block; [63:32] = L0, [31:0] = R0.
- decrypt  in  1  sampled with block_in; 1 = reverse key order.
- key_idx  out  CNT_W  index of the round key needed this cycle.
- round_key  in  48  round key for key_idx; must be valid combinationally in the same cycle.
- out_valid  out  1  block_out is valid.
- out_ready  in  1  consumer accepts block_out.
- block_out  out  64  result block.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Registers: L[31:0], R[31:0], cnt[CNT_W-1:0], mode.
- Reset (rst=1 at an edge): state=IDLE, L=R=0, cnt=0, mode=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, key_idx=0, block_out=0.
  - Reset overrides everything, including mid-RUN and in DONE; any partial block is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: L<=block_in[63:32], R<=block_in[31:0], mode<=decrypt, cnt<=0, go to RUN.
- RUN:
  - in_ready=0. key_idx = mode ? (ROUNDS-1-cnt) : cnt.
  - Each edge: L<=R, R<=L ^ F(R, round_key), where F is fblock (Rin=R, r_key=round_key).
  - If cnt==ROUNDS-1, go to DONE; else cnt<=cnt+1.
- DONE:
  - out_valid=1, in_ready=0, L/R held.
  - block_out = FINAL_SWAP ? {L,R} : {R,L}.
  - On out_ready=1: go to IDLE, out_valid falls at that edge.
  - With out_ready=0, hold indefinitely; block_out stays stable.
- block_out is 0 whenever out_valid=0 (masked), so the bench can check it.
- key_idx equals cnt in IDLE/DONE. round_key is ignored outside RUN.
- Latency:
  - out_valid rises exactly ROUNDS edges after the accepting edge.
  - Minimum initiation interval is ROUNDS+2 cycles: accept, ROUNDS rounds, one DONE cycle with out_ready=1.
  - No new block is accepted in the same cycle as a DONE handshake.
- in_valid while busy is ignored; the upstream stage holds it (valid/ready rule: data is stable while valid and not ready).
- ROUNDS=1: a single RUN cycle with key_idx=0 in both modes.
- Decrypt property: with FINAL_SWAP=0 and identical keys, decrypting an encryption output restores the original block.

Test Plan:
- DES known-answer, ROUNDS=16, FINAL_SWAP=0.
  - Setup: bench applies IP/FP and models the key schedule (K=133457799BBCDFF1) as the round_key lookup.
  - Stimulus: plaintext 0123456789ABCDEF.
  - Response: 85E813540F0AB405; out_valid exactly 16 edges after accept.
  - key_idx sequence 0..15.
- Decrypt of 85E813540F0AB405 with the same keys.
  - Response: 0123456789ABCDEF; key_idx sequence 15..0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Response: block_out stable, in_ready=0, second in_valid not accepted; block accepted only after the out_ready handshake plus one IDLE cycle.
- Reset mid-operation: assert rst at round 7.
  - Response: next cycle state IDLE, out_valid=0, block_out=0, busy=0, key_idx=0.
  - A fresh block then completes correctly.
- Parameter variant ROUNDS=1, FINAL_SWAP=1, round_key=0.
  - Stimulus: block_in=AAAAAAAA55555555.
  - Response: block_out = {55555555, AAAAAAAA ^ F(55555555,0)}, one edge after accept.
- Back-to-back random streams, 200 blocks, random in_valid/out_ready.
  - Response: every output matches the scoreboard model; no drop or duplication; spacing ≥ ROUNDS+2 cycles.
